// File: rtl/video_if.sv
// video_if: panel-side raster bundle (pixel clock, syncs, active flag, RGB).
interface video_if;
  logic        clk;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [23:0] rgb;
  modport master (output clk, hs, vs, blank, rgb);
  modport slave  (input  clk, hs, vs, blank, rgb);
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen: parametrised VGA/LCD raster timing with registered test-pattern RGB.
module vga_timing_pattern_gen #(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int HFP       = 40,
  parameter int HPULSE    = 48,
  parameter int HBP       = 40,
  parameter int VFP       = 13,
  parameter int VPULSE    = 3,
  parameter int VBP       = 29,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int GRID_LOG2 = 4
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [23:0]                solid_rgb,
  video_if.master                    video_ifm,
  output logic [$clog2(HDISP)-1:0]   x,
  output logic [$clog2(VDISP)-1:0]   y,
  output logic                       sof,
  output logic                       sol,
  output logic [15:0]                frame_cnt
);
  localparam int XLEN  = HDISP + HFP + HPULSE + HBP;
  localparam int YLEN  = VDISP + VFP + VPULSE + VBP;
  localparam int PXW   = $clog2(XLEN);
  localparam int PYW   = $clog2(YLEN);
  localparam int XW    = $clog2(HDISP);
  localparam int YW    = $clog2(VDISP);
  localparam int BAR_W = HDISP / 8;
  localparam logic [PXW-1:0] X_LAST = PXW'(XLEN - 1);
  localparam logic [PXW-1:0] X_DISP = PXW'(HDISP);
  localparam logic [PXW-1:0] HS_ON  = PXW'(HDISP + HFP);
  localparam logic [PXW-1:0] HS_OFF = PXW'(HDISP + HFP + HPULSE);
  localparam logic [PYW-1:0] Y_LAST = PYW'(YLEN - 1);
  localparam logic [PYW-1:0] Y_DISP = PYW'(VDISP);
  localparam logic [PYW-1:0] VS_ON  = PYW'(VDISP + VFP);
  localparam logic [PYW-1:0] VS_OFF = PYW'(VDISP + VFP + VPULSE);
  localparam logic [XW-1:0]  BAR_LAST = XW'(BAR_W - 1);
  localparam logic HS_A = 1'(HS_POL);
  localparam logic VS_A = 1'(VS_POL);
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]     mode_q, mode_d, mode_e;
  logic [23:0]    solid_q, solid_d, solid_e;
  logic [XW-1:0]  sc_q, sc_d;
  logic [2:0]     bar_q, bar_d;
  logic           hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, sof_q, sof_d, sol_q, sol_d;
  logic [23:0]    rgb_q, rgb_d, pat;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           line_end, frame_end, frame_start, act, grid;
  logic [7:0]     x8, y8;
  always_comb begin
    line_end    = px_q == X_LAST;
    frame_end   = line_end && py_q == Y_LAST;
    frame_start = en && px_q == '0 && py_q == '0;
    px_d        = en ? (line_end ? '0 : px_q + 1'b1) : px_q;
    py_d        = (en && line_end) ? (frame_end ? '0 : py_q + 1'b1) : py_q;
    frame_cnt_d = (en && frame_end) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    // the frame's first pixel already uses the newly sampled mode/colour
    mode_e      = frame_start ? mode : mode_q;
    solid_e     = frame_start ? solid_rgb : solid_q;
    mode_d      = mode_e;
    solid_d     = solid_e;
    sc_d        = !en ? sc_q : (line_end || sc_q == BAR_LAST) ? '0 : sc_q + 1'b1;
    bar_d       = !en ? bar_q : line_end ? 3'd0 :
                  (sc_q == BAR_LAST && bar_q != 3'd7) ? bar_q + 3'd1 : bar_q;
    act         = px_q < X_DISP && py_q < Y_DISP;
    x8          = 8'(px_q);
    y8          = 8'(py_q);
    grid        = x8[GRID_LOG2-1:0] == '0 || y8[GRID_LOG2-1:0] == '0;
    pat         = mode_e == 2'd0 ? (grid ? 24'hFFFFFF : 24'h000000) :
                  mode_e == 2'd1 ? BARS[bar_q] :
                  mode_e == 2'd2 ? solid_e :
                  {x8 + frame_cnt_q[7:0], y8, 8'h80};
    hs_d        = en ? ((px_q >= HS_ON && px_q < HS_OFF) ? HS_A : ~HS_A) : hs_q;
    vs_d        = en ? ((py_q >= VS_ON && py_q < VS_OFF) ? VS_A : ~VS_A) : vs_q;
    blank_d     = en ? act : blank_q;
    rgb_d       = en ? (act ? pat : 24'h0) : rgb_q;
    x_d         = en ? (act ? px_q[XW-1:0] : '0) : x_q;
    y_d         = en ? (act ? py_q[YW-1:0] : '0) : y_q;
    sof_d       = frame_start;
    sol_d       = en && px_q == '0 && py_q < Y_DISP;
  end
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      px_q        <= '0;
      py_q        <= '0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      solid_q     <= '0;
      sc_q        <= '0;
      bar_q       <= '0;
      hs_q        <= ~HS_A;
      vs_q        <= ~VS_A;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sof_q       <= 1'b0;
      sol_q       <= 1'b0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      solid_q     <= solid_d;
      sc_q        <= sc_d;
      bar_q       <= bar_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      rgb_q       <= rgb_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sof_q       <= sof_d;
      sol_q       <= sol_d;
    end
  end
  assign video_ifm.clk   = pixel_clk;
  assign video_ifm.hs    = hs_q;
  assign video_ifm.vs    = vs_q;
  assign video_ifm.blank = blank_q;
  assign video_ifm.rgb   = rgb_q;
  assign x         = x_q;
  assign y         = y_q;
  assign sof       = sof_q;
  assign sol       = sol_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb_vga_timing_pattern_gen: directed checks of raster timing, patterns, mode latch, freeze and reset.
module tb_vga_timing_pattern_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic [3:0]  x;
  logic [2:0]  y;
  logic        sof, sol;
  logic [15:0] frame_cnt;
  video_if vif();
  vga_timing_pattern_gen #(
    .HDISP(16), .VDISP(8), .HFP(2), .HPULSE(3), .HBP(2),
    .VFP(1), .VPULSE(2), .VBP(1), .HS_POL(0), .VS_POL(0), .GRID_LOG2(2)
  ) dut (
    .pixel_clk(clk), .pixel_rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .video_ifm(vif), .x(x), .y(y), .sof(sof), .sol(sol), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int checks = 0;
  int fails = 0;
  int bpx = 0, bpy = 0, bfc = 0, opx = 0, opy = 0, ofc = 0;
  logic [23:0] fr [276];
  function automatic logic [23:0] exp_rgb(int m, int px, int py, logic [23:0] s, int fc);
    logic [7:0] r;
    if (px >= 16 || py >= 8) return 24'h0;
    case (m)
      0: return (px % 4 == 0 || py % 4 == 0) ? 24'hFFFFFF : 24'h0;
      1: return BARS[(px / 2 > 7) ? 7 : px / 2];
      2: return s;
      default: begin
        r = 8'(px + fc);
        return {r, 8'(py), 8'h80};
      end
    endcase
  endfunction
  // {hs, vs, blank, sof, sol} expected for the pixel at counter position (px, py)
  function automatic logic [4:0] exp_ctl(int px, int py);
    return {!(px >= 18 && px < 21), !(py >= 9 && py < 11), (px < 16 && py < 8),
            (px == 0 && py == 0), (px == 0 && py < 8)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    opx = bpx;
    opy = bpy;
    ofc = bfc;
    if (rst) begin
      bpx = 0; bpy = 0; bfc = 0;
    end else if (en) begin
      if (bpx == 22) begin
        bpx = 0;
        if (bpy == 11) begin bpy = 0; bfc++; end else bpy++;
      end else bpx++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    tick(); tick();
    checks++; if ({vif.hs, vif.vs, vif.blank, sof, sol} !== 5'b11000) begin fails++; $display("FAIL reset_ctl got %b exp 11000", {vif.hs, vif.vs, vif.blank, sof, sol}); end
    checks++; if (vif.rgb !== 24'h0) begin fails++; $display("FAIL reset_rgb got %h exp 000000", vif.rgb); end
    checks++; if ({x, y} !== 7'd0) begin fails++; $display("FAIL reset_xy got %0d,%0d exp 0,0", x, y); end
    checks++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_fcnt got %0d exp 0", frame_cnt); end
    rst = 1'b0;
  endtask
  task automatic test_frames();
    int ns = 0, nsol = 0, nhs = 0, nvs = 0, nbl = 0, last = -1, bad_gap = 0;
    logic [6:0] exy;
    mode = 2'd0; en = 1'b1;
    for (int k = 0; k < 828; k++) begin
      tick();
      checks++; if ({vif.hs, vif.vs, vif.blank, sof, sol} !== exp_ctl(opx, opy)) begin fails++; $display("FAIL frames_ctl px=%0d py=%0d got %b exp %b", opx, opy, {vif.hs, vif.vs, vif.blank, sof, sol}, exp_ctl(opx, opy)); end
      checks++; if (vif.rgb !== exp_rgb(0, opx, opy, 24'h0, 0)) begin fails++; $display("FAIL frames_rgb px=%0d py=%0d got %h exp %h", opx, opy, vif.rgb, exp_rgb(0, opx, opy, 24'h0, 0)); end
      exy = (opx < 16 && opy < 8) ? {4'(opx), 3'(opy)} : 7'd0;
      checks++; if ({x, y} !== exy) begin fails++; $display("FAIL frames_xy px=%0d py=%0d got %0d,%0d exp %0d,%0d", opx, opy, x, y, exy[6:3], exy[2:0]); end
      if (k < 276) fr[k] = vif.rgb;
      if (sof) begin
        if (last >= 0 && k - last != 276) bad_gap++;
        last = k; ns++;
      end
      nsol += int'(sol); nhs += int'(!vif.hs); nvs += int'(!vif.vs); nbl += int'(vif.blank);
    end
    checks++; if (ns != 3) begin fails++; $display("FAIL sof_count got %0d exp 3", ns); end
    checks++; if (bad_gap != 0) begin fails++; $display("FAIL sof_period bad gaps %0d exp 0", bad_gap); end
    checks++; if (nsol != 24) begin fails++; $display("FAIL sol_count got %0d exp 24", nsol); end
    checks++; if (nhs != 108) begin fails++; $display("FAIL hs_low_count got %0d exp 108", nhs); end
    checks++; if (nvs != 138) begin fails++; $display("FAIL vs_low_count got %0d exp 138", nvs); end
    checks++; if (nbl != 384) begin fails++; $display("FAIL blank_count got %0d exp 384", nbl); end
    checks++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL frame_cnt got %0d exp 3", frame_cnt); end
  endtask
  task automatic test_grid();
    int nz = 0;
    checks++; if (fr[0] !== 24'hFFFFFF) begin fails++; $display("FAIL grid_0_0 got %h exp FFFFFF", fr[0]); end
    checks++; if (fr[27] !== 24'hFFFFFF) begin fails++; $display("FAIL grid_4_1 got %h exp FFFFFF", fr[27]); end
    checks++; if (fr[28] !== 24'h000000) begin fails++; $display("FAIL grid_5_1 got %h exp 000000", fr[28]); end
    for (int k = 0; k < 276; k++)
      if ((k % 23 >= 16 || k / 23 >= 8) && fr[k] !== 24'h0) nz++;
    checks++; if (nz != 0) begin fails++; $display("FAIL grid_blanked nonzero=%0d exp 0", nz); end
  endtask
  task automatic test_bars();
    mode = 2'd1;
    for (int k = 0; k < 276; k++) begin
      tick();
      fr[k] = vif.rgb;
      checks++; if (vif.rgb !== exp_rgb(1, opx, opy, 24'h0, 0)) begin fails++; $display("FAIL bars_rgb px=%0d py=%0d got %h exp %h", opx, opy, vif.rgb, exp_rgb(1, opx, opy, 24'h0, 0)); end
    end
    checks++; if (fr[0] !== 24'hFFFFFF || fr[1] !== 24'hFFFFFF) begin fails++; $display("FAIL bars_x01 got %h %h exp FFFFFF", fr[0], fr[1]); end
    checks++; if (fr[2] !== 24'hFFFF00) begin fails++; $display("FAIL bars_x2 got %h exp FFFF00", fr[2]); end
    checks++; if (fr[104] !== 24'h0000FF) begin fails++; $display("FAIL bars_x12 got %h exp 0000FF", fr[104]); end
    checks++; if (fr[14] !== 24'h0 || fr[15] !== 24'h0) begin fails++; $display("FAIL bars_x1415 got %h %h exp 000000", fr[14], fr[15]); end
  endtask
  task automatic test_gradient();
    mode = 2'd3;
    for (int k = 0; k < 276; k++) begin
      tick();
      checks++; if (vif.rgb !== exp_rgb(3, opx, opy, 24'h0, ofc)) begin fails++; $display("FAIL grad_rgb px=%0d py=%0d got %h exp %h", opx, opy, vif.rgb, exp_rgb(3, opx, opy, 24'h0, ofc)); end
    end
  endtask
  task automatic test_mode_switch();
    mode = 2'd2; solid_rgb = 24'h123456;
    for (int k = 0; k < 276; k++) begin
      if (k == 69) begin mode = 2'd0; solid_rgb = 24'hABCDEF; end
      tick();
      checks++; if (vif.rgb !== exp_rgb(2, opx, opy, 24'h123456, 0)) begin fails++; $display("FAIL switch_old px=%0d py=%0d got %h exp %h", opx, opy, vif.rgb, exp_rgb(2, opx, opy, 24'h123456, 0)); end
    end
    for (int k = 0; k < 276; k++) begin
      tick();
      checks++; if (vif.rgb !== exp_rgb(0, opx, opy, 24'h0, 0)) begin fails++; $display("FAIL switch_new px=%0d py=%0d got %h exp %h", opx, opy, vif.rgb, exp_rgb(0, opx, opy, 24'h0, 0)); end
    end
  endtask
  task automatic test_freeze_reset();
    logic [33:0] snap;
    logic [15:0] fsnap;
    for (int k = 0; k < 139; k++) tick();
    checks++; if (sol !== 1'b1 || {x, y} !== {4'd0, 3'd6}) begin fails++; $display("FAIL pre_freeze sol=%b x=%0d y=%0d exp 1,0,6", sol, x, y); end
    snap = {vif.hs, vif.vs, vif.blank, vif.rgb, x, y};
    fsnap = frame_cnt;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if ({vif.hs, vif.vs, vif.blank, vif.rgb, x, y} !== snap) begin fails++; $display("FAIL freeze_hold got %h exp %h", {vif.hs, vif.vs, vif.blank, vif.rgb, x, y}, snap); end
      checks++; if ({sof, sol} !== 2'b00) begin fails++; $display("FAIL freeze_pulses got %b exp 00", {sof, sol}); end
      checks++; if (frame_cnt !== fsnap) begin fails++; $display("FAIL freeze_fcnt got %0d exp %0d", frame_cnt, fsnap); end
    end
    en = 1'b1;
    tick();
    checks++; if ({x, y} !== {4'd1, 3'd6}) begin fails++; $display("FAIL resume_xy got %0d,%0d exp 1,6", x, y); end
    for (int k = 0; k < 17; k++) tick();
    checks++; if (vif.hs !== 1'b0 || opx != 18) begin fails++; $display("FAIL pre_reset_hs got %b at px=%0d exp 0 at 18", vif.hs, opx); end
    rst = 1'b1;
    tick();
    checks++; if ({vif.hs, vif.vs, vif.blank, sof, sol} !== 5'b11000) begin fails++; $display("FAIL midrst_ctl got %b exp 11000", {vif.hs, vif.vs, vif.blank, sof, sol}); end
    checks++; if (vif.rgb !== 24'h0 || {x, y} !== 7'd0) begin fails++; $display("FAIL midrst_data rgb=%h x=%0d y=%0d exp 0", vif.rgb, x, y); end
    checks++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL midrst_fcnt got %0d exp 0", frame_cnt); end
    rst = 1'b0; en = 1'b0;
    tick(); tick();
    checks++; if (sof !== 1'b0) begin fails++; $display("FAIL idle_sof got %b exp 0", sof); end
    en = 1'b1;
    tick();
    checks++; if ({sof, sol, vif.blank} !== 3'b111 || {x, y} !== 7'd0) begin fails++; $display("FAIL restart sof/sol/blank=%b x=%0d y=%0d exp 111,0,0", {sof, sol, vif.blank}, x, y); end
    checks++; if (vif.rgb !== 24'hFFFFFF) begin fails++; $display("FAIL restart_rgb got %h exp FFFFFF", vif.rgb); end
  endtask
  initial begin
    test_reset();
    test_frames();
    test_grid();
    test_bars();
    test_gradient();
    test_mode_switch();
    test_freeze_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
